buffered_input_port: RTL and testbench
======================================

BUFFERED_INPUT_PORT -- requirements
Module: buffered_input_port

Interface
REQ-001 SHALL have parameter FLIT_W, default 32: flit width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: width of each router coordinate (X, Y).
REQ-003 SHALL have parameter DEPTH, default 4: flit buffer entries, power of two, >= 2.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_flit  input  FLIT_W: incoming flit.
REQ-007 SHALL have port in_valid  input  1: in_flit valid.
REQ-008 SHALL have port in_ready  output  1: buffer can accept a flit.
REQ-009 SHALL have port router_x, router_y  input  ADDR_W each: this router's coordinates.
REQ-010 SHALL have port port_block  input  1: stall; forces all out_valid low.
REQ-011 SHALL have port out_flit  output  FLIT_W: flit at buffer head, shared by all output ports.
REQ-012 SHALL have port out_valid  output  5: one-hot; bit 0 Local, 1 North, 2 East, 3 South, 4 West.
REQ-013 SHALL have port out_ready  input  5: per-port downstream ready.
REQ-014 SHALL have port err_drop  output  1: one-cycle pulse when an orphan flit is dropped.
REQ-015 SHALL have ports flit_count, drop_count  output  16 each: statistics (see Configuration).

Function
REQ-016 Flit fields SHALL be: type = [FLIT_W-1:FLIT_W-2] (01 head, 00 body, 10 tail, 11 single); dest_x = next ADDR_W bits down; dest_y = the ADDR_W bits below dest_x.
REQ-017 A flit SHALL be written when in_valid && in_ready; in_ready = buffer not full; no write when full, even if a pop occurs the same cycle.
REQ-018 A written flit SHALL become visible at the buffer head the following cycle.
REQ-019 Routing SHALL be X-then-Y: dest_x > router_x -> East; dest_x < router_x -> West; else dest_y > router_y -> North; dest_y < router_y -> South; else Local (unsigned compare).
REQ-020 FSM SHALL have states IDLE and ACTIVE.
REQ-021 In IDLE with head flit type 01 or 11 at buffer head: latch route register, go ACTIVE next cycle; no pop that cycle.
REQ-022 In IDLE with type 00 or 10 at buffer head: pop it, pulse err_drop for that cycle, stay IDLE.
REQ-023 In ACTIVE, buffer non-empty and port_block low: out_valid = one-hot of latched route, out_flit = buffer head; otherwise out_valid = 0.
REQ-024 Pop SHALL occur when out_valid[r] && out_ready[r]; only the routed port's ready is considered.
REQ-025 Popping a tail (10) or single (11) flit SHALL return FSM to IDLE next cycle; body flits keep route locked (wormhole).
REQ-026 Minimum latency SHALL be 2 cycles from head-flit write to out_valid assertion; 1 flit/cycle sustained in ACTIVE.
REQ-027 Buffer pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1; simultaneous push and pop leaves occupancy unchanged.
REQ-028 Empty buffer in ACTIVE SHALL hold route and keep out_valid low until the next flit arrives.

Reset
REQ-029 reset_n low SHALL asynchronously clear pointers and occupancy, set FSM IDLE, clear route to Local, and drive out_valid = 0, err_drop = 0, in_ready = 1, flit_count = drop_count = 0; out_flit content is don't-care while out_valid = 0.
REQ-030 Reset mid-packet SHALL discard all buffered flits; the next flit after deassertion is treated per REQ-021/022.

Configuration
REQ-031 Macro BUFFERED_INPUT_PORT_STATS_EN defined: flit_count increments on each pop to an output port, drop_count on each err_drop, both saturating at 16'hFFFF.
REQ-032 Macro undefined: flit_count and drop_count SHALL be tied to 0 with no counter logic; all other behaviour identical.

Verification
REQ-033 router (2,2), single flit dest (3,1), out_ready all 1 -> out_valid = 5'b00100 (East) exactly 2 cycles after write, popped in that cycle.
REQ-034 router (2,2), head dest (2,2) + 2 body + tail, out_ready[0] low 3 cycles -> flits held in order, all four exit on Local, FSM IDLE after tail.
REQ-035 DEPTH=4, out_ready = 0, 5 consecutive valid flits -> in_ready low after 4th write, 5th not accepted until a pop.
REQ-036 body flit (type 00) at head in IDLE -> popped, err_drop pulses 1 cycle, drop_count = 1 with STATS_EN.
REQ-037 port_block high during packet -> out_valid = 0 and no pops; deassert -> forwarding resumes on same port.
REQ-038 reset_n low mid-packet with 3 flits buffered -> in_ready = 1, out_valid = 0 immediately; FSM IDLE and buffer empty after release.

Source files
------------

// File: rtl/buffered_input_port.sv
// Wormhole router input port: flit FIFO, X-then-Y route computation and per-packet route lock.
// Optional statistics counters are enabled with `define BUFFERED_INPUT_PORT_STATS_EN.
module buffered_input_port #(
    parameter int FLIT_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] router_x,
    input  logic [ADDR_W-1:0] router_y,
    input  logic              port_block,
    output logic [FLIT_W-1:0] out_flit,
    output logic [4:0]        out_valid,
    input  logic [4:0]        out_ready,
    output logic              err_drop,
    output logic [15:0]       flit_count,
    output logic [15:0]       drop_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:0]        state_q, state_d;
    logic [2:0]        route_q, route_d, calc_route;

    logic              empty, push, pop, drop_pop, fwd_pop;
    logic [FLIT_W-1:0] head_flit;
    logic [1:0]        head_type;
    logic [ADDR_W-1:0] dest_x, dest_y;

    assign head_flit = mem_q[rd_ptr_q];
    assign head_type = head_flit[FLIT_W-1 -: 2];
    assign dest_x    = head_flit[FLIT_W-3 -: ADDR_W];
    assign dest_y    = head_flit[FLIT_W-3-ADDR_W -: ADDR_W];

    assign empty    = (cnt_q == '0);
    assign in_ready = (cnt_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = drop_pop || fwd_pop;
    assign out_flit = head_flit;
    assign err_drop = drop_pop;

    always_comb begin
        calc_route = P_LOCAL;
        if (dest_x > router_x)      calc_route = P_EAST;
        else if (dest_x < router_x) calc_route = P_WEST;
        else if (dest_y > router_y) calc_route = P_NORTH;
        else if (dest_y < router_y) calc_route = P_SOUTH;
    end

    // Bit 0 of the type marks packet starts (head/single), bit 1 packet ends (tail/single).
    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        out_valid = '0;
        drop_pop  = 1'b0;
        fwd_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (head_type[0]) begin
                        route_d = calc_route;
                        state_d = S_ACTIVE;
                    end else begin
                        drop_pop = 1'b1;
                    end
                end
            end
            default: begin
                if (!empty && !port_block) begin
                    out_valid = 5'(5'b00001 << route_q);
                    fwd_pop   = |(out_valid & out_ready);
                    if (fwd_pop && head_type[1]) state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            route_q  <= P_LOCAL;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q   <= cnt_d;
            state_q <= state_d;
            route_q <= route_d;
        end
    end

`ifdef BUFFERED_INPUT_PORT_STATS_EN
    logic [15:0] flit_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flit_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (fwd_pop && flit_cnt_q != 16'hFFFF)  flit_cnt_q <= flit_cnt_q + 16'd1;
            if (drop_pop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign flit_count = flit_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign flit_count = '0;
    assign drop_count = '0;
`endif

    logic unused_dirs;
    assign unused_dirs = ^{P_NORTH, P_SOUTH};

endmodule

// File: tb/tb_buffered_input_port.sv
// Self-checking bench for buffered_input_port: directed scenarios plus random traffic
// against a queue-based packet model.
module tb_buffered_input_port;
    localparam int FW = 32;
    localparam int AW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] router_x = 4'd2;
    logic [AW-1:0] router_y = 4'd2;
    logic          port_block = 1'b0;
    logic [FW-1:0] out_flit;
    logic [4:0]    out_valid;
    logic [4:0]    out_ready = '0;
    logic          err_drop;
    logic [15:0]   flit_count, drop_count;

    buffered_input_port #(.FLIT_W(FW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(in_ready), .router_x(router_x), .router_y(router_y),
        .port_block(port_block), .out_flit(out_flit), .out_valid(out_valid),
        .out_ready(out_ready), .err_drop(err_drop), .flit_count(flit_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: buffered flits in order, whether a packet route is locked, and which port.
    logic [FW-1:0] q[$];
    bit            active;
    int            route;
    int            fwds, drops;

    logic [4:0]    exp_ov;
    logic [FW-1:0] exp_flit;
    logic          exp_err, exp_rdy, do_pop;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int dx, input int dy, input int pl);
        logic [21:0] p;
        p = 22'(pl);
        return {t, 4'(dx), 4'(dy), p};
    endfunction

    function automatic int dir_of(input logic [FW-1:0] f, input logic [AW-1:0] rx, input logic [AW-1:0] ry);
        int dx, dy;
        dx = int'(f[29:26]);
        dy = int'(f[25:22]);
        if (dx > int'(rx)) return 2;
        if (dx < int'(rx)) return 4;
        if (dy > int'(ry)) return 1;
        if (dy < int'(ry)) return 3;
        return 0;
    endfunction

    task automatic model_clear();
        q.delete();
        active = 0;
        route  = 0;
        fwds   = 0;
        drops  = 0;
    endtask

    // Apply inputs just after a rising edge, then derive what the port should show this cycle.
    task automatic drive(input logic v, input logic [FW-1:0] f, input logic [4:0] rdy, input logic blk);
        logic [FW-1:0] hf;
        in_valid = v; in_flit = f; out_ready = rdy; port_block = blk;
        #2;
        exp_rdy = (q.size() < D);
        exp_ov = '0; exp_err = 1'b0; exp_flit = '0; do_pop = 1'b0;
        if (q.size() > 0) begin
            hf = q[0];
            if (!active) begin
                if (hf[31:30] == 2'b00 || hf[31:30] == 2'b10) begin
                    exp_err = 1'b1;
                    do_pop  = 1'b1;
                end
            end else if (!blk) begin
                exp_ov   = 5'(1 << route);
                exp_flit = hf;
                do_pop   = rdy[route];
            end
        end
    endtask

    task automatic advance();
        logic [FW-1:0] hf;
        logic          acc;
        acc = in_valid && exp_rdy;
        if (q.size() > 0) begin
            hf = q[0];
            if (!active) begin
                if (hf[31:30] == 2'b01 || hf[31:30] == 2'b11) begin
                    active = 1;
                    route  = dir_of(hf, router_x, router_y);
                end else begin
                    void'(q.pop_front());
                    drops++;
                end
            end else if (do_pop) begin
                void'(q.pop_front());
                fwds++;
                if (hf[31]) active = 0;
            end
        end
        if (acc) q.push_back(in_flit);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total += 5;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        if (out_valid !== 5'b0) begin bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        if (err_drop !== 1'b0) begin bad++; $display("FAIL reset err_drop got %b want 0", err_drop); end
        if (flit_count !== 16'd0) begin bad++; $display("FAIL reset flit_count got %0d want 0", flit_count); end
        if (drop_count !== 16'd0) begin bad++; $display("FAIL reset drop_count got %0d want 0", drop_count); end
        model_clear();
        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_east_single();
        router_x = 4'd2; router_y = 4'd2;
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, mk(2'b11, 3, 1, 32'h1234), 5'b11111, 1'b0);
            total += 3;
            if (out_valid !== exp_ov) begin bad++; $display("FAIL east c%0d out_valid got %b want %b", c, out_valid, exp_ov); end
            if (err_drop !== exp_err) begin bad++; $display("FAIL east c%0d err_drop got %b want %b", c, err_drop, exp_err); end
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL east c%0d in_ready got %b want %b", c, in_ready, exp_rdy); end
            if (c == 2) begin
                total += 2;
                if (out_valid !== 5'b00100) begin bad++; $display("FAIL east_latency out_valid got %b want 00100", out_valid); end
                if (out_flit !== mk(2'b11, 3, 1, 32'h1234)) begin bad++; $display("FAIL east_flit got %h", out_flit); end
            end
            advance();
        end
    endtask

    task automatic test_wormhole_local();
        logic [FW-1:0] pkt [4];
        int local_pops = 0;
        pkt[0] = mk(2'b01, 2, 2, 'h10); pkt[1] = mk(2'b00, 7, 9, 'h11);
        pkt[2] = mk(2'b00, 1, 5, 'h12); pkt[3] = mk(2'b10, 0, 0, 'h13);
        for (int c = 0; c < 10; c++) begin
            drive(c < 4, pkt[c % 4], (c < 3) ? 5'b11110 : 5'b11111, 1'b0);
            total += 3;
            if (out_valid !== exp_ov) begin bad++; $display("FAIL worm c%0d out_valid got %b want %b", c, out_valid, exp_ov); end
            if (err_drop !== exp_err) begin bad++; $display("FAIL worm c%0d err_drop got %b want %b", c, err_drop, exp_err); end
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL worm c%0d in_ready got %b want %b", c, in_ready, exp_rdy); end
            if (exp_ov != 0) begin
                total++;
                if (out_flit !== exp_flit) begin bad++; $display("FAIL worm c%0d out_flit got %h want %h", c, out_flit, exp_flit); end
            end
            if (out_valid === 5'b00001 && out_ready[0]) local_pops++;
            advance();
        end
        total += 2;
        if (local_pops !== 4) begin bad++; $display("FAIL worm_local_pops got %0d want 4", local_pops); end
        drive(1'b0, '0, 5'b11111, 1'b0);
        if (out_valid !== 5'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL worm_idle out_valid %b in_ready %b want 0/1", out_valid, in_ready); end
        advance();
    endtask

    task automatic test_full();
        logic [FW-1:0] pkt [5];
        int sent = 0;
        pkt[0] = mk(2'b01, 5, 2, 'h20); pkt[1] = mk(2'b00, 0, 0, 'h21);
        pkt[2] = mk(2'b00, 0, 0, 'h22); pkt[3] = mk(2'b10, 0, 0, 'h23);
        pkt[4] = mk(2'b11, 0, 2, 'h24);
        for (int c = 0; c < 16; c++) begin
            drive(sent < 5, pkt[sent % 5], (c < 7) ? 5'b00000 : 5'b11111, 1'b0);
            total += 3;
            if (out_valid !== exp_ov) begin bad++; $display("FAIL full c%0d out_valid got %b want %b", c, out_valid, exp_ov); end
            if (err_drop !== exp_err) begin bad++; $display("FAIL full c%0d err_drop got %b want %b", c, err_drop, exp_err); end
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL full c%0d in_ready got %b want %b", c, in_ready, exp_rdy); end
            if (exp_ov != 0) begin
                total++;
                if (out_flit !== exp_flit) begin bad++; $display("FAIL full c%0d out_flit got %h want %h", c, out_flit, exp_flit); end
            end
            if (c >= 4 && c < 7) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL full_stall c%0d in_ready got %b want 0", c, in_ready); end
            end
            if (in_valid && exp_rdy) sent++;
            advance();
        end
        total++;
        if (q.size() != 0 || sent != 5) begin bad++; $display("FAIL full_drain model left %0d sent %0d want 0/5", q.size(), sent); end
    endtask

    task automatic test_orphan();
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, mk(2'b00, 1, 1, 'h30), 5'b11111, 1'b0);
            total += 3;
            if (out_valid !== exp_ov) begin bad++; $display("FAIL orphan c%0d out_valid got %b want %b", c, out_valid, exp_ov); end
            if (err_drop !== exp_err) begin bad++; $display("FAIL orphan c%0d err_drop got %b want %b", c, err_drop, exp_err); end
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL orphan c%0d in_ready got %b want %b", c, in_ready, exp_rdy); end
            advance();
        end
        total += 2;
`ifdef BUFFERED_INPUT_PORT_STATS_EN
        if (drop_count !== 16'(drops)) begin bad++; $display("FAIL orphan drop_count got %0d want %0d", drop_count, drops); end
        if (flit_count !== 16'(fwds)) begin bad++; $display("FAIL orphan flit_count got %0d want %0d", flit_count, fwds); end
`else
        if (drop_count !== 16'd0) begin bad++; $display("FAIL orphan drop_count got %0d want 0", drop_count); end
        if (flit_count !== 16'd0) begin bad++; $display("FAIL orphan flit_count got %0d want 0", flit_count); end
`endif
    endtask

    task automatic test_block();
        logic [FW-1:0] pkt [3];
        int north_pops = 0;
        pkt[0] = mk(2'b01, 2, 3, 'h40); pkt[1] = mk(2'b00, 0, 0, 'h41); pkt[2] = mk(2'b10, 0, 0, 'h42);
        for (int c = 0; c < 11; c++) begin
            drive(c < 3, pkt[c % 3], 5'b11111, (c >= 2 && c < 6));
            total += 3;
            if (out_valid !== exp_ov) begin bad++; $display("FAIL block c%0d out_valid got %b want %b", c, out_valid, exp_ov); end
            if (err_drop !== exp_err) begin bad++; $display("FAIL block c%0d err_drop got %b want %b", c, err_drop, exp_err); end
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL block c%0d in_ready got %b want %b", c, in_ready, exp_rdy); end
            if (exp_ov != 0) begin
                total++;
                if (out_flit !== exp_flit) begin bad++; $display("FAIL block c%0d out_flit got %h want %h", c, out_flit, exp_flit); end
            end
            if (out_valid === 5'b00010) north_pops++;
            advance();
        end
        total++;
        if (north_pops !== 3) begin bad++; $display("FAIL block_north_pops got %0d want 3", north_pops); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, mk(c == 0 ? 2'b01 : 2'b00, 1, 2, 'h50 + c), 5'b00000, 1'b0);
            advance();
        end
        drive(1'b0, '0, 5'b11111, 1'b0);
        total++;
        if (out_valid !== 5'b10000) begin bad++; $display("FAIL rstmid_pre out_valid got %b want 10000", out_valid); end
        reset_n = 1'b0;
        #1;
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid in_ready got %b want 1", in_ready); end
        if (out_valid !== 5'b0) begin bad++; $display("FAIL rstmid out_valid got %b want 0", out_valid); end
        model_clear();
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, mk(2'b10, 3, 3, 'h5F), 5'b11111, 1'b0);
            total += 3;
            if (out_valid !== exp_ov) begin bad++; $display("FAIL rstmid c%0d out_valid got %b want %b", c, out_valid, exp_ov); end
            if (err_drop !== exp_err) begin bad++; $display("FAIL rstmid c%0d err_drop got %b want %b", c, err_drop, exp_err); end
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL rstmid c%0d in_ready got %b want %b", c, in_ready, exp_rdy); end
            advance();
        end
    endtask

    task automatic test_random();
        logic [1:0] t;
        router_x = 4'($urandom_range(0, 3));
        router_y = 4'($urandom_range(0, 3));
        for (int c = 0; c < 500; c++) begin
            t = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0,
                  mk(t, $urandom_range(0, 3), $urandom_range(0, 3), $urandom),
                  5'($urandom), $urandom_range(0, 7) == 0);
            total += 3;
            if (out_valid !== exp_ov) begin bad++; $display("FAIL rand c%0d out_valid got %b want %b", c, out_valid, exp_ov); end
            if (err_drop !== exp_err) begin bad++; $display("FAIL rand c%0d err_drop got %b want %b", c, err_drop, exp_err); end
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand c%0d in_ready got %b want %b", c, in_ready, exp_rdy); end
            if (exp_ov != 0) begin
                total++;
                if (out_flit !== exp_flit) begin bad++; $display("FAIL rand c%0d out_flit got %h want %h", c, out_flit, exp_flit); end
            end
            advance();
        end
        total += 2;
`ifdef BUFFERED_INPUT_PORT_STATS_EN
        if (flit_count !== 16'(fwds)) begin bad++; $display("FAIL rand flit_count got %0d want %0d", flit_count, fwds); end
        if (drop_count !== 16'(drops)) begin bad++; $display("FAIL rand drop_count got %0d want %0d", drop_count, drops); end
`else
        if (flit_count !== 16'd0) begin bad++; $display("FAIL rand flit_count got %0d want 0", flit_count); end
        if (drop_count !== 16'd0) begin bad++; $display("FAIL rand drop_count got %0d want 0", drop_count); end
`endif
    endtask

    initial begin
        model_clear();
        #2;
        test_reset();
        test_east_single();
        test_wormhole_local();
        test_full();
        test_orphan();
        test_block();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
